// File: rtl/mux_nch_scan_reg.sv
// N-channel registered multiplexer with valid/ready output handshake.
// A channel is chosen either by software (manual) or by round-robin scan with a per-channel dwell.
module mux_nch_scan_reg #(
  parameter int N_CH  = 8,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH),
  parameter int DWELL = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic                    enable,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    sel_load,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int               DW_W    = $clog2(DWELL + 1);
  localparam logic [SEL_W:0]   N_CH_X  = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(N_CH - 1);
  localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL - 1);

  logic [SEL_W-1:0] ch_q, ch_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] och_q, och_d;
  logic             valid_q, valid_d;
  logic             mode_prev_q;

  logic [WIDTH-1:0] chan_sel;
  logic             slot;
  logic             sel_ok;
  logic             mode_chg;

  always_comb begin
    chan_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch_q == SEL_W'(k)) chan_sel = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign slot     = enable & (~valid_q | out_ready);
  assign sel_ok   = sel_load & ({1'b0, sel} < N_CH_X);
  assign mode_chg = (mode != mode_prev_q);

  always_comb begin
    data_d  = data_q;
    och_d   = och_q;
    valid_d = valid_q;
    ch_d    = ch_q;
    dwell_d = dwell_q;

    if (slot) begin
      data_d  = chan_sel;
      och_d   = ch_q;
      valid_d = 1'b1;
    end else if (!enable && valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    // Priority: a valid select strobe, then a mode switch, then scan advance.
    if (sel_ok) begin
      ch_d    = sel;
      dwell_d = '0;
    end else if (mode_chg) begin
      dwell_d = '0;
    end else if (mode && slot) begin
      if (dwell_q == DW_LAST) begin
        dwell_d = '0;
        ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // Tracked through reset so a steady mode is not seen as a change afterwards.
    mode_prev_q <= mode;
    if (reset) begin
      ch_q    <= '0;
      dwell_q <= '0;
      data_q  <= '0;
      och_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ch_q    <= ch_d;
      dwell_q <= dwell_d;
      data_q  <= data_d;
      och_q   <= och_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_ch    = och_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_nch_scan_reg.sv
// Scoreboard bench for mux_nch_scan_reg: an 8-channel and a 6-channel instance,
// directed stimulus pushes expected {ch,data}; monitors pop on every accepted sample.
module tb_mux_nch_scan_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic [63:0] in8;
  logic        en8, mode8, sl8, rdy8;
  logic [2:0]  sel8;
  logic [7:0]  od8;
  logic [2:0]  oc8;
  logic        ov8;

  logic [47:0] in6;
  logic        en6, mode6, sl6, rdy6;
  logic [2:0]  sel6;
  logic [7:0]  od6;
  logic [2:0]  oc6;
  logic        ov6;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] q8[$];
  logic [10:0] q6[$];
  logic [10:0] e8, e6;

  mux_nch_scan_reg #(.N_CH(8), .WIDTH(8), .DWELL(4)) dut8 (
    .clk(clk), .reset(reset), .in_data(in8), .enable(en8), .mode(mode8),
    .sel(sel8), .sel_load(sl8), .out_data(od8), .out_ch(oc8),
    .out_valid(ov8), .out_ready(rdy8)
  );

  mux_nch_scan_reg #(.N_CH(6), .WIDTH(8), .DWELL(4)) dut6 (
    .clk(clk), .reset(reset), .in_data(in6), .enable(en6), .mode(mode6),
    .sel(sel6), .sel_load(sl6), .out_data(od6), .out_ch(oc6),
    .out_valid(ov6), .out_ready(rdy6)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat8(input logic [7:0] base);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = base + 8'(k);
    return r;
  endfunction

  function automatic logic [47:0] pat6(input logic [7:0] base);
    logic [47:0] r;
    for (int k = 0; k < 6; k++) r[k*8 +: 8] = base + 8'(k);
    return r;
  endfunction

  task automatic push8(input int ch, input int d, input int n);
    repeat (n) q8.push_back({3'(ch), 8'(d)});
  endtask

  task automatic push6(input int ch, input int d, input int n);
    repeat (n) q6.push_back({3'(ch), 8'(d)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && ov8 && rdy8) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut8 extra sample: got ch %0d data %0h, expected none", oc8, od8);
      end else begin
        e8 = q8.pop_front();
        chk("dut8 sample {ch,data}", {21'b0, oc8, od8}, {21'b0, e8});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ov6 && rdy6) begin
      if (q6.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut6 extra sample: got ch %0d data %0h, expected none", oc6, od6);
      end else begin
        e6 = q6.pop_front();
        chk("dut6 sample {ch,data}", {21'b0, oc6, od6}, {21'b0, e6});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in8 = {$urandom, $urandom};
    en8 = 1'b1; mode8 = 1'b0; sl8 = 1'b0; rdy8 = 1'b1; sel8 = '0;
    in6 = pat6(8'h20);
    en6 = 1'b0; mode6 = 1'b0; sl6 = 1'b0; rdy6 = 1'b1; sel6 = '0;

    // Reset held two cycles with random data and enable high
    step();
    in8 = {$urandom, $urandom};
    step();
    chk("reset out_valid", 32'(ov8), 32'd0);
    chk("reset out_data",  32'(od8), 32'd0);
    chk("reset out_ch",    32'(oc8), 32'd0);

    // Manual select of channel 5; the strobe edge still loads channel 0
    reset = 1'b0;
    in8  = pat8(8'h10);
    sel8 = 3'd5; sl8 = 1'b1;
    push8(0, 8'h10, 1);
    step();
    sl8 = 1'b0;
    push8(5, 8'h15, 5);
    repeat (5) step();
    en8 = 1'b0;
    step(); step();
    chk("manual drain out_valid", 32'(ov8), 32'd0);
    chk("manual held out_data",   32'(od8), 32'h15);
    chk("manual held out_ch",     32'(oc8), 32'd5);

    // Scan through all channels and wrap back to 0
    reset = 1'b1; mode8 = 1'b1;
    step();
    reset = 1'b0; en8 = 1'b1;
    for (int i = 0; i < 33; i++) push8((i / 4) % 8, 8'h10 + (i / 4) % 8, 1);
    repeat (33) step();
    en8 = 1'b0;
    step(); step();
    chk("scan drain out_valid", 32'(ov8), 32'd0);

    // Stall mid-dwell on channel 0 (two samples already taken)
    en8 = 1'b1;
    push8(0, 8'h10, 2);
    step(); step();
    rdy8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) in8 = pat8(8'h50);
      chk("stall out_ch frozen",   32'(oc8), 32'd0);
      chk("stall out_data frozen", 32'(od8), 32'h10);
      chk("stall out_valid held",  32'(ov8), 32'd1);
    end
    rdy8 = 1'b1;
    push8(0, 8'h50, 1);
    push8(1, 8'h51, 4);
    push8(2, 8'h52, 1);
    repeat (6) step();
    en8 = 1'b0;
    step(); step();

    // Reach ch 3 dwell 2, then reset with a sample pending
    en8 = 1'b1;
    push8(2, 8'h52, 3);
    push8(3, 8'h53, 1);
    repeat (5) step();
    rdy8 = 1'b0; reset = 1'b1;
    step();
    chk("mid-scan reset out_valid", 32'(ov8), 32'd0);
    chk("mid-scan reset out_ch",    32'(oc8), 32'd0);
    chk("mid-scan reset out_data",  32'(od8), 32'd0);
    reset = 1'b0; rdy8 = 1'b1;
    push8(0, 8'h50, 4);
    push8(1, 8'h51, 1);
    repeat (5) step();
    en8 = 1'b0;
    step();
    chk("enable-off out_valid after accept", 32'(ov8), 32'd0);
    step();
    chk("enable-off out_valid stays low", 32'(ov8), 32'd0);
    chk("enable-off out_data held",       32'(od8), 32'h51);
    chk("enable-off out_ch held",         32'(oc8), 32'd1);

    // Six-channel build: out-of-range select is ignored
    en6 = 1'b1; sel6 = 3'd7; sl6 = 1'b1;
    push6(0, 8'h20, 1);
    step();
    sl6 = 1'b0;
    push6(0, 8'h20, 2);
    repeat (2) step();
    en6 = 1'b0;
    step(); step();
    chk("dut6 drain out_valid", 32'(ov6), 32'd0);
    mode6 = 1'b1;
    step();

    // Select strobe on the scan-advance edge of channel 0 wins over advancing to 1
    en6 = 1'b1; sel6 = 3'd2;
    push6(0, 8'h20, 4);
    push6(2, 8'h22, 4);
    push6(3, 8'h23, 1);
    for (int i = 0; i < 9; i++) begin
      sl6 = (i == 3);
      step();
    end
    sl6 = 1'b0; en6 = 1'b0;
    step(); step();

    chk("dut8 scoreboard empty", 32'(q8.size()), 32'd0);
    chk("dut6 scoreboard empty", 32'(q6.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
